// File: rtl/boxcar_decimator.sv
// Boxcar (moving-block) averaging decimator: sums 2^L offset-corrected samples and emits one clamped average.
// Define BOXCAR_DECIMATOR_ROUND_EN for round-half-up; otherwise the average truncates toward minus infinity.
module boxcar_decimator #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_LOG_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid,
  input  logic signed [DATA_WIDTH-1:0] offset,
  input  logic [3:0]                   log_div,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_valid,
  output logic                         sat_flag
);

  localparam int AW = DATA_WIDTH + 1 + MAX_LOG_DIV;
  localparam int CW = MAX_LOG_DIV + 1;
  localparam logic [3:0] MAX_L = 4'(MAX_LOG_DIV);
  localparam logic signed [AW:0] Y_MAX = (AW+1)'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [AW:0] Y_MIN = (AW+1)'(-(2**(DATA_WIDTH-1)));

  logic [3:0]                   l_reg;
  logic [3:0]                   l_eff;
  logic                         need_latch;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                last_idx;
  logic signed [AW-1:0]         acc;
  logic signed [DATA_WIDTH:0]   d;
  logic signed [AW-1:0]         sum;
  logic signed [AW:0]           rnd;
  logic signed [AW:0]           rsum;
  logic signed [AW:0]           shifted;
  logic signed [DATA_WIDTH-1:0] r_clamped;
  logic                         r_sat;
  logic                         frame_done;

  // At frame start the ratio is taken straight from log_div so the first sample already uses it.
  assign l_eff = need_latch ? ((log_div > MAX_L) ? MAX_L : log_div) : l_reg;

  assign d          = $signed({x_in[DATA_WIDTH-1], x_in}) - $signed({offset[DATA_WIDTH-1], offset});
  assign sum        = acc + AW'(d);
  assign last_idx   = CW'((32'd1 << l_eff) - 32'd1);
  assign frame_done = x_valid && !clr && (cnt == last_idx);

  always_comb begin
    rnd = '0;
`ifdef BOXCAR_DECIMATOR_ROUND_EN
    if (l_eff != 4'd0) rnd = (AW+1)'(1) << (l_eff - 4'd1);
`endif
    rsum    = (AW+1)'(sum) + rnd;
    shifted = rsum >>> l_eff;
  end

  always_comb begin
    r_clamped = shifted[DATA_WIDTH-1:0];
    r_sat     = 1'b0;
    if (shifted > Y_MAX) begin
      r_clamped = Y_MAX[DATA_WIDTH-1:0];
      r_sat     = 1'b1;
    end else if (shifted < Y_MIN) begin
      r_clamped = Y_MIN[DATA_WIDTH-1:0];
      r_sat     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_out      <= '0;
      y_valid    <= 1'b0;
      sat_flag   <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      l_reg      <= 4'd0;
      need_latch <= 1'b1;
    end else begin
      y_valid <= 1'b0;
      if (clr) begin
        cnt        <= '0;
        acc        <= '0;
        sat_flag   <= 1'b0;
        need_latch <= 1'b1;
      end else begin
        if (need_latch) begin
          l_reg      <= l_eff;
          need_latch <= 1'b0;
        end
        if (x_valid) begin
          if (frame_done) begin
            cnt        <= '0;
            acc        <= '0;
            y_out      <= r_clamped;
            y_valid    <= 1'b1;
            need_latch <= 1'b1;
            if (r_sat) sat_flag <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            acc <= sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Self-checking bench for boxcar_decimator: frame-level average model plus directed literal checks.
module tb_boxcar_decimator;
  localparam int DW = 16;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic x_valid = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] offset = '0;
  logic [3:0] log_div = 4'd2;
  logic signed [DW-1:0] y_out;
  logic y_valid;
  logic sat_flag;

  int checks = 0;
  int failures = 0;

  boxcar_decimator #(.DATA_WIDTH(DW), .MAX_LOG_DIV(ML)) dut (
    .clk(clk), .rst(rst), .clr(clr), .x_in(x_in), .x_valid(x_valid),
    .offset(offset), .log_div(log_div), .y_out(y_out), .y_valid(y_valid),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Frame model: collect the differences of a frame, then average the whole block at once.
  longint m_y = 0;
  bit m_v = 1'b0;
  bit m_sat = 1'b0;
  int m_L = 0;
  bit m_pend = 1'b1;
  longint frame_q[$];

  function automatic longint block_avg(input longint s, input int L);
    longint p, q, rs;
    p = longint'(1) << L;
    rs = s;
`ifdef BOXCAR_DECIMATOR_ROUND_EN
    if (L > 0) rs = s + p / 2;
`endif
    q = rs / p;
    if (rs < 0 && (rs % p) != 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y = 0; m_v = 1'b0; m_sat = 1'b0; m_L = 0; m_pend = 1'b1;
      frame_q.delete();
    end else begin
      m_v = 1'b0;
      if (clr) begin
        frame_q.delete();
        m_sat = 1'b0;
        m_pend = 1'b1;
      end else begin
        if (m_pend) begin
          m_L = (int'(log_div) > ML) ? ML : int'(log_div);
          m_pend = 1'b0;
        end
        if (x_valid) begin
          frame_q.push_back(longint'(x_in) - longint'(offset));
          if (frame_q.size() == (1 << m_L)) begin
            longint r;
            r = block_avg(frame_q.sum(), m_L);
            if (r > 32767) begin r = 32767; m_sat = 1'b1; end
            if (r < -32768) begin r = -32768; m_sat = 1'b1; end
            m_y = r;
            m_v = 1'b1;
            frame_q.delete();
            m_pend = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_y_valid", longint'(y_valid), longint'(m_v));
      chk("model_y_out", longint'(y_out), m_y);
      chk("model_sat_flag", longint'(sat_flag), longint'(m_sat));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic sample(input longint x);
    x_valid = 1'b1;
    x_in = 16'(x);
    step();
    x_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_y_out", longint'(y_out), 0);
    chk("reset_y_valid", longint'(y_valid), 0);
    chk("reset_sat", longint'(sat_flag), 0);
    step();
    rst = 1'b0;

    // 4-sample average of 100..400
    sample(100); sample(200); sample(300);
    chk("avg4_no_early_strobe", longint'(y_valid), 0);
    sample(400);
    log_div = 4'd1;
    chk("avg4_strobe", longint'(y_valid), 1);
    chk("avg4_y_out", longint'(y_out), 250);
    chk("avg4_sat", longint'(sat_flag), 0);
    idle(1);
    chk("avg4_strobe_one_cycle", longint'(y_valid), 0);
    chk("avg4_hold", longint'(y_out), 250);

    // Rounding vs truncation on pairs
    sample(1); sample(2);
`ifdef BOXCAR_DECIMATOR_ROUND_EN
    chk("pair_pos", longint'(y_out), 2);
`else
    chk("pair_pos", longint'(y_out), 1);
`endif
    sample(-1); sample(-2);
    log_div = 4'd0;
    offset = -16'sd32768;
`ifdef BOXCAR_DECIMATOR_ROUND_EN
    chk("pair_neg", longint'(y_out), -1);
`else
    chk("pair_neg", longint'(y_out), -2);
`endif

    // L=0 saturation, sticky flag
    sample(32767);
    chk("sat_pos_y_out", longint'(y_out), 32767);
    chk("sat_pos_flag", longint'(sat_flag), 1);
    offset = 16'sd0;
    sample(5);
    chk("l0_pass_y_out", longint'(y_out), 5);
    chk("sat_sticky", longint'(sat_flag), 1);
    offset = 16'sd32767;
    sample(-32768);
    chk("sat_neg_y_out", longint'(y_out), -32768);
    offset = 16'sd0;
    log_div = 4'd2;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_sat", longint'(sat_flag), 0);
    chk("clr_hold_y_out", longint'(y_out), -32768);

    // Mid-frame log_div change has no effect until the frame completes
    sample(4); sample(8);
    log_div = 4'd0;
    sample(12);
    chk("midchg_no_strobe", longint'(y_valid), 0);
    sample(16);
    chk("midchg_frame_y_out", longint'(y_out), 10);
    sample(7);
    chk("midchg_l0_first", longint'(y_out), 7);
    sample(-3);
    log_div = 4'd2;
    chk("midchg_l0_second", longint'(y_out), -3);

    // clr with simultaneous valid drops the sample and the partial frame
    sample(1); sample(2); sample(3);
    clr = 1'b1; x_valid = 1'b1; x_in = 16'sd99;
    step();
    clr = 1'b0; x_valid = 1'b0;
    chk("clr_no_strobe", longint'(y_valid), 0);
    chk("clr_hold", longint'(y_out), -3);
    sample(10); sample(10); sample(10);
    chk("post_clr_no_early", longint'(y_valid), 0);
    sample(10);
    chk("post_clr_y_out", longint'(y_out), 10);

    // Asynchronous reset mid-frame, then a frame with valid gaps
    sample(50); sample(60);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_y_out", longint'(y_out), 0);
    chk("rst_async_y_valid", longint'(y_valid), 0);
    step();
    rst = 1'b0;
    sample(20); idle(2); sample(20); sample(20);
    chk("gap_no_early", longint'(y_valid), 0);
    sample(20);
    chk("post_rst_y_out", longint'(y_out), 20);

    // Sweep of ratios including the clamp above MAX_LOG_DIV
    for (int k = 0; k <= 5; k++) begin
      int n;
      log_div = 4'(k);
      n = 1 << ((k > ML) ? ML : k);
      for (int i = 0; i < n; i++) begin
        offset = 16'(i * 37 - 200);
        if (k == 4) sample(32767);
        else sample(longint'($urandom_range(0, 65535)) - 32768);
        if (i == 1) idle(1);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boxcar_decimator.md
BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the signed sample width of input, offset and output.
REQ-002 The block SHALL have parameter MAX_LOG_DIV, default 4, giving the largest supported log2 decimation ratio.
REQ-003 Port clk, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port clr, input, 1 bit: synchronous frame clear.
REQ-006 Port x_in, input, DATA_WIDTH bits: signed ADC sample.
REQ-007 Port x_valid, input, 1 bit: x_in is valid this cycle.
REQ-008 Port offset, input, DATA_WIDTH bits: signed DC offset subtracted from each sample.
REQ-009 Port log_div, input, 4 bits: requested log2 decimation ratio.
REQ-010 Port y_out, output, DATA_WIDTH bits: signed decimated sample feeding the downstream IIR stage.
REQ-011 Port y_valid, output, 1 bit: one-cycle strobe marking a new y_out.
REQ-012 Port sat_flag, output, 1 bit: sticky output-saturation indicator.

Function
REQ-013 Each accepted sample SHALL be d = x_in - offset, computed at DATA_WIDTH+1 bits without overflow.
REQ-014 A sample SHALL be accepted on a rising clk edge when x_valid=1 and clr=0.
REQ-015 The accumulator SHALL be DATA_WIDTH+1+MAX_LOG_DIV bits and SHALL never wrap.
REQ-016 The active ratio L SHALL be min(log_div, MAX_LOG_DIV), latched only at frame start (after reset, after clr, or after a frame completes).
REQ-017 A log_div change mid-frame SHALL NOT affect the current frame.
REQ-018 A frame SHALL complete on acceptance of its 2^L-th sample; the sample counter then returns to zero and the accumulator restarts with the next accepted sample.
REQ-019 On frame completion the block SHALL compute r = (sum + round) >>> L (arithmetic), where round is defined in Configuration.
REQ-020 r SHALL be clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if clamping occurs, sat_flag SHALL be set.
REQ-021 y_out and y_valid SHALL update on the clk edge after the completing sample is accepted (latency 1 cycle).
REQ-022 y_valid SHALL be high for exactly one cycle per completed frame; y_out SHALL hold its value between strobes.
REQ-023 When L=0, every accepted sample SHALL produce one output (d clamped).
REQ-024 x_valid gaps SHALL stall counting only; partial sums SHALL be kept.
REQ-025 clr=1 SHALL discard the partial frame, zero the counter and accumulator, clear sat_flag, and relatch L. clr has priority over a simultaneous x_valid, whose sample is dropped. y_out SHALL be held and y_valid SHALL be 0.
REQ-026 sat_flag SHALL remain set until clr or rst.

Reset
REQ-027 rst=1 SHALL immediately force y_out=0, y_valid=0, sat_flag=0, counter=0 and accumulator=0, and latch L=0. L is relatched from log_div at the first clk edge after rst deasserts.
REQ-028 rst asserted mid-frame SHALL discard the partial frame with no output strobe.

Configuration
REQ-029 The rounding mode SHALL be selected by the macro BOXCAR_DECIMATOR_ROUND_EN.
REQ-030 With BOXCAR_DECIMATOR_ROUND_EN defined, round SHALL be 2^(L-1) for L>0 and 0 for L=0, giving round-half-up.
REQ-031 With BOXCAR_DECIMATOR_ROUND_EN undefined, round SHALL be 0 (truncation toward minus infinity).

Verification
REQ-032 log_div=2, offset=0, x_in=100,200,300,400 on consecutive valid cycles -> one y_valid pulse one cycle after the 4th sample, y_out=250, sat_flag=0.
REQ-033 log_div=1, x_in=1,2 then -1,-2 -> with ROUND_EN y_out=2 then -1; without ROUND_EN y_out=1 then -2.
REQ-034 log_div=0, offset=-32768, x_in=32767 -> y_out=32767 one cycle later, sat_flag=1, and sat_flag stays 1 until clr.
REQ-035 log_div=2; accept 2 samples, change log_div to 0 -> first output only after the 4th sample, then one output per valid sample.
REQ-036 log_div=2; accept 3 samples, then clr together with x_valid -> no y_valid; the next 4 samples (10,10,10,10) give y_out=10.
REQ-037 rst pulsed after 2 of 4 samples -> y_out=0, y_valid=0 immediately; the next full frame averages only post-reset samples.
